// File: rtl/bk_prefix_sum_pipe.sv
// bk_prefix_sum_pipe
//   8-bit Brent-Kung prefix adder back end with a valid/ready pipeline.
//   Takes bitwise propagate/generate pairs (bit 0 carries the carry-in)
//   and produces the sum bits and carry-out 3 cycles after accept
//   (PIPE_MID=1) or 2 cycles after accept (PIPE_MID=0).
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   P_0..P_8, G_0..G_8 propagate / generate inputs (P_0 = 0, G_0 = carry-in)
//   IN_VALID/IN_READY  input handshake
//   S_1..S_8, C_8      sum bits and carry-out
//   OUT_VALID/OUT_READY output handshake
module bk_prefix_sum_pipe #(
    parameter int PIPE_MID = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic P_0,
    input  logic P_1,
    input  logic P_2,
    input  logic P_3,
    input  logic P_4,
    input  logic P_5,
    input  logic P_6,
    input  logic P_7,
    input  logic P_8,
    input  logic G_0,
    input  logic G_1,
    input  logic G_2,
    input  logic G_3,
    input  logic G_4,
    input  logic G_5,
    input  logic G_6,
    input  logic G_7,
    input  logic G_8,
    input  logic IN_VALID,
    output logic IN_READY,
    output logic S_1,
    output logic S_2,
    output logic S_3,
    output logic S_4,
    output logic S_5,
    output logic S_6,
    output logic S_7,
    output logic S_8,
    output logic C_8,
    output logic OUT_VALID,
    input  logic OUT_READY
);

    // Group pairs are packed as {g, p}; hi covers the more significant bits.
    function automatic logic [1:0] bk_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    function automatic logic [1:0] bit_pg(input logic [8:0] p, input logic [8:0] g,
                                          input int idx);
        return {g[idx], p[idx]};
    endfunction

    logic [8:0] p_in;
    logic [8:0] g_in;
    logic       accept;

    logic [8:0] p_p0;
    logic [8:0] g_p0;
    logic       vld_p0;
    logic       ld_p0;
    logic       ld_nxt;

    logic [1:0] up10_c, up32_c, up54_c, up76_c, up30_c, up74_c, up70_c;

    logic [8:0] p_m;
    logic [8:0] g_m;
    logic [1:0] up10_m, up30_m, up54_m, up70_m;
    logic       vld_m;

    logic [1:0] dn50, dn20, dn40, dn60, dn80;
    logic [8:0] gg;
    logic [8:1] sum_c;

    logic [8:1] s_p2;
    logic       c8_p2;
    logic       vld_p2;
    logic       ld_p2;

    // Group-propagate terms of prefixes that already include bit 0 never
    // reach a sum, nor do the odd raw generates after the up-sweep.
    logic       unused_pg;

    assign p_in   = {P_8, P_7, P_6, P_5, P_4, P_3, P_2, P_1, P_0};
    assign g_in   = {G_8, G_7, G_6, G_5, G_4, G_3, G_2, G_1, G_0};

    assign ld_p2    = !vld_p2 || OUT_READY;
    assign ld_p0    = !vld_p0 || ld_nxt;
    // Ready depends only on downstream state and reset, never on IN_VALID.
    assign IN_READY = ld_p0 && !RST;
    assign accept   = IN_VALID && IN_READY;

    // ---- stage 1: input register ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0 <= 1'b0;
            p_p0   <= '0;
            g_p0   <= '0;
        end else begin
            if (ld_p0) begin
                vld_p0 <= IN_VALID;
            end
            if (accept) begin
                p_p0 <= p_in;
                g_p0 <= g_in;
            end
        end
    end

    // Up-sweep: pairs, quads, then the full byte.
    assign up10_c = bk_op(bit_pg(p_p0, g_p0, 1), bit_pg(p_p0, g_p0, 0));
    assign up32_c = bk_op(bit_pg(p_p0, g_p0, 3), bit_pg(p_p0, g_p0, 2));
    assign up54_c = bk_op(bit_pg(p_p0, g_p0, 5), bit_pg(p_p0, g_p0, 4));
    assign up76_c = bk_op(bit_pg(p_p0, g_p0, 7), bit_pg(p_p0, g_p0, 6));
    assign up30_c = bk_op(up32_c, up10_c);
    assign up74_c = bk_op(up76_c, up54_c);
    assign up70_c = bk_op(up74_c, up30_c);

    generate
        if (PIPE_MID != 0) begin : g_mid
            logic [8:0] p_p1;
            logic [8:0] g_p1;
            logic [1:0] up10_p1, up30_p1, up54_p1, up70_p1;
            logic       vld_p1;
            logic       ld_p1;

            assign ld_p1 = !vld_p1 || ld_p2;

            // ---- stage 2: up-sweep results plus raw bits for the down-sweep ----
            always_ff @(posedge CLK) begin
                if (RST) begin
                    vld_p1  <= 1'b0;
                    p_p1    <= '0;
                    g_p1    <= '0;
                    up10_p1 <= '0;
                    up30_p1 <= '0;
                    up54_p1 <= '0;
                    up70_p1 <= '0;
                end else begin
                    if (ld_p1) begin
                        vld_p1 <= vld_p0;
                    end
                    if (ld_p1 && vld_p0) begin
                        p_p1    <= p_p0;
                        g_p1    <= g_p0;
                        up10_p1 <= up10_c;
                        up30_p1 <= up30_c;
                        up54_p1 <= up54_c;
                        up70_p1 <= up70_c;
                    end
                end
            end

            assign ld_nxt = ld_p1;
            assign vld_m  = vld_p1;
            assign p_m    = p_p1;
            assign g_m    = g_p1;
            assign up10_m = up10_p1;
            assign up30_m = up30_p1;
            assign up54_m = up54_p1;
            assign up70_m = up70_p1;
        end else begin : g_no_mid
            assign ld_nxt = ld_p2;
            assign vld_m  = vld_p0;
            assign p_m    = p_p0;
            assign g_m    = g_p0;
            assign up10_m = up10_c;
            assign up30_m = up30_c;
            assign up54_m = up54_c;
            assign up70_m = up70_c;
        end
    endgenerate

    // Down-sweep fills in the remaining prefixes.
    assign dn50 = bk_op(up54_m, up30_m);
    assign dn20 = bk_op(bit_pg(p_m, g_m, 2), up10_m);
    assign dn40 = bk_op(bit_pg(p_m, g_m, 4), up30_m);
    assign dn60 = bk_op(bit_pg(p_m, g_m, 6), dn50);
    assign dn80 = bk_op(bit_pg(p_m, g_m, 8), up70_m);

    assign gg = {dn80[1], up70_m[1], dn60[1], dn50[1], dn40[1],
                 up30_m[1], dn20[1], up10_m[1], g_m[0]};

    assign sum_c = p_m[8:1] ^ gg[7:0];

    assign unused_pg = ^{p_m[0], g_m[1], g_m[3], g_m[5], g_m[7],
                         dn20[0], dn40[0], dn60[0], dn80[0], up70_m[0]};

    // ---- output stage: sums and carry-out ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p2 <= 1'b0;
            s_p2   <= '0;
            c8_p2  <= 1'b0;
        end else begin
            if (ld_p2) begin
                vld_p2 <= vld_m;
            end
            if (ld_p2 && vld_m) begin
                s_p2  <= sum_c;
                c8_p2 <= gg[8];
            end
        end
    end

    assign S_1       = s_p2[1];
    assign S_2       = s_p2[2];
    assign S_3       = s_p2[3];
    assign S_4       = s_p2[4];
    assign S_5       = s_p2[5];
    assign S_6       = s_p2[6];
    assign S_7       = s_p2[7];
    assign S_8       = s_p2[8];
    assign C_8       = c8_p2;
    assign OUT_VALID = vld_p2;

endmodule

// File: doc/bk_prefix_sum_pipe.md
BK_PREFIX_SUM_PIPE -- requirements
Module: bk_prefix_sum_pipe

Interface
REQ-001 Parameter PIPE_MID, default 1: 1 = mid-tree register present (3 stages); 0 = mid register bypassed (2 stages).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 P_0, G_0  input  1 each  bit-0 pair; P_0 tied 0, G_0 = carry-in C_0.
REQ-005 P_1..P_8  input  1 each  bitwise propagate, P_i = A_i xor B_i.
REQ-006 G_1..G_8  input  1 each  bitwise generate, G_i = A_i and B_i.
REQ-007 IN_VALID  input  1  P/G set valid this cycle.
REQ-008 IN_READY  output  1  block accepts P/G this cycle.
REQ-009 S_1..S_8  output  1 each  sum bits.
REQ-010 C_8  output  1  carry-out.
REQ-011 OUT_VALID  output  1  S/C_8 valid.
REQ-012 OUT_READY  input  1  downstream accepts S/C_8 this cycle.

Function
REQ-013 Prefix operator SHALL be (g,p)o(g',p') = (g or (p and g'), p and p'); GG_i = group generate over bits i..0.
REQ-014 Up-sweep SHALL form (1:0),(3:2),(5:4),(7:6); then (3:0),(7:4); then (7:0).
REQ-015 Down-sweep SHALL form (5:0)=(5:4)o(3:0); then (2:0),(4:0),(6:0) from single bits with (1:0),(3:0),(5:0); (8:0)=G_8/P_8 o (7:0).
REQ-016 Sums: S_i = P_i xor GG_(i-1), i=1..8; C_8 = GG_8.
REQ-017 Stage 1 SHALL register inputs P_0..8, G_0..8 on accept (IN_VALID and IN_READY).
REQ-018 With PIPE_MID=1, stage 2 SHALL register up-sweep results plus raw P/G needed by the down-sweep; stage 3 SHALL register S_1..S_8, C_8.
REQ-019 With PIPE_MID=0, stage 2 SHALL be omitted; output register fed directly from stage 1 through the full tree.
REQ-020 Latency accept-to-OUT_VALID: 3 cycles (PIPE_MID=1), 2 cycles (PIPE_MID=0); throughput 1 result/cycle with OUT_READY high.
REQ-021 Each stage k has valid bit v_k; stage k SHALL load when v_k=0 or stage k+1 loads (output stage: OUT_VALID=0 or OUT_READY=1).
REQ-022 IN_READY = stage-1 load condition; combinational from OUT_READY permitted; no combinational path from IN_VALID to IN_READY.
REQ-023 Stage with v_k=1 that cannot advance SHALL hold data and valid unchanged (no overwrite, no drop, no duplication).
REQ-024 Bubbles SHALL collapse: empty stage loads regardless of downstream stall.
REQ-025 S/C_8 SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 IN_VALID with IN_READY=0 SHALL be ignored (upstream holds).
REQ-027 Capacity: 3 results in flight (PIPE_MID=1), 2 (PIPE_MID=0).

Reset
REQ-028 RST=1 at a rising edge SHALL clear all valid bits, all data registers, S_1..S_8, C_8 to 0; OUT_VALID=0.
REQ-029 RST mid-operation SHALL discard all in-flight results; no result emitted for data accepted before reset.
REQ-030 During RST=1, IN_READY=0; first accept possible in cycle after RST deasserts.

Verification
REQ-031 A=0x5A,B=0x3C,C_0=0 (P=0x66,G=0x18), OUT_READY=1 -> after 3 cycles S=0x96, C_8=0, OUT_VALID one cycle.
REQ-032 A=0xFF,B=0x01,C_0=0 (P=0xFE,G=0x01) -> S=0x00, C_8=1; A=0xFF,B=0x00,C_0=1 (P=0xFF,G=0) -> S=0x00, C_8=1.
REQ-033 Back-to-back 8 random sets, OUT_READY=1 -> 8 consecutive OUT_VALID cycles, in order, matching A+B+C_0.
REQ-034 OUT_READY=0, feed 4 sets -> first 3 accepted, IN_READY=0 on 4th; release OUT_READY -> 3 results in order, 4th accepted same cycle, none lost.
REQ-035 Assert RST with 2 results in flight -> OUT_VALID=0 next cycle, no stale result after release.
REQ-036 Repeat REQ-031/034 with PIPE_MID=0 -> latency 2, capacity 2.
